// File: rtl/cache_types.sv
// Types and default widths shared by the L2, the line-wide bus adapter and
// cacheline_adapter.
package cache_types;

  localparam int unsigned CL_S_OFFSET   = 5;
  localparam int unsigned CL_BEAT_WIDTH = 64;
  localparam int unsigned CL_LINE_WIDTH = (2 ** CL_S_OFFSET) * 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } cla_state_t;

  // Beats per line; callers keep the result a power of two and at least 2.
  function automatic int unsigned num_beats(input int unsigned s_offset,
                                            input int unsigned beat_width);
    return ((2 ** s_offset) * 8) / beat_width;
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Splits L2 line reads/writebacks into fixed-length memory bursts and
// reassembles fill lines. Optional counters: CACHELINE_ADAPTER_PERF_EN.
module cacheline_adapter
  import cache_types::*;
#(
  parameter int unsigned s_offset   = CL_S_OFFSET,
  parameter int unsigned beat_width = CL_BEAT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(2**s_offset)*8-1:0]  line_i,
  output logic [(2**s_offset)*8-1:0]  line_o,
  input  logic [31:0]                 address_i,
  input  logic                        read_i,
  input  logic                        write_i,
  output logic                        resp_o,
  input  logic [beat_width-1:0]       burst_i,
  output logic [beat_width-1:0]       burst_o,
  output logic [31:0]                 address_o,
  output logic                        read_o,
  output logic                        write_o,
  input  logic                        resp_i
`ifdef CACHELINE_ADAPTER_PERF_EN
  ,
  output logic [31:0]                 rd_count_o,
  output logic [31:0]                 wr_count_o
`endif
);

  localparam int unsigned       line_w    = (2 ** s_offset) * 8;
  localparam int unsigned       beats     = num_beats(s_offset, beat_width);
  localparam int unsigned       cnt_w     = $clog2(beats);
  localparam logic [cnt_w-1:0]  last_beat = cnt_w'(beats - 1);
  localparam logic [31:0]       addr_mask = ~((32'd1 << s_offset) - 32'd1);

  cla_state_t          state_q, state_d;
  logic [cnt_w-1:0]    k_q;
  logic [31:0]         addr_q;
  logic [line_w-1:0]   rd_buf_q;  // fill line; survives writebacks untouched
  logic [line_w-1:0]   wr_buf_q;  // latched writeback line

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no branch leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (read_i)       state_d = READ;
               else if (write_i) state_d = WRITE;
      READ,
      WRITE:   if (resp_i && k_q == last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: line buffers are reset because line_o/burst_o must read 0 out of reset.
      k_q      <= '0;
      addr_q   <= '0;
      rd_buf_q <= '0;
      wr_buf_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (read_i) begin
            addr_q <= address_i & addr_mask;
            k_q    <= '0;
          end else if (write_i) begin
            addr_q   <= address_i & addr_mask;
            wr_buf_q <= line_i;
            k_q      <= '0;
          end
        end
        READ: if (resp_i) begin
          rd_buf_q[k_q*beat_width +: beat_width] <= burst_i;
          k_q <= k_q + cnt_w'(1);
        end
        WRITE: if (resp_i) k_q <= k_q + cnt_w'(1);
        default: ;
      endcase
    end
  end

  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = rd_buf_q;
  assign burst_o   = wr_buf_q[k_q*beat_width +: beat_width];

`ifdef CACHELINE_ADAPTER_PERF_EN
  // Remembers the direction of the request leaving IDLE for the DONE tally.
  logic txn_rd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn_rd_q   <= 1'b0;
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      if (state_q == IDLE) txn_rd_q <= read_i;
      if (state_q == DONE) begin
        if (txn_rd_q) begin
          if (rd_count_o != '1) rd_count_o <= rd_count_o + 32'd1;
        end else begin
          if (wr_count_o != '1) wr_count_o <= wr_count_o + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: table of line transactions plus
// hand sequences for simultaneous requests, mid-burst reset and stray acks.
module tb_cacheline_adapter;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] line_i, line_o;
  logic [31:0]   address_i, address_o;
  logic          read_i, write_i, resp_o;
  logic [BW-1:0] burst_i, burst_o;
  logic          read_o, write_o, resp_i;
`ifdef CACHELINE_ADAPTER_PERF_EN
  logic [31:0]   rd_count_o, wr_count_o;
`endif

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
`ifdef CACHELINE_ADAPTER_PERF_EN
    ,
    .rd_count_o(rd_count_o),
    .wr_count_o(wr_count_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [LW-1:0] line;   // memory content for reads, writeback line for writes
    int          stall_beat;
    int          stall_n;
  } vec_t;

  vec_t          vecs[5];
  logic [BW-1:0] exp_beats[$];
  logic [LW-1:0] exp_lines[$];
  logic [31:0]   cur_addr;
  logic [LW-1:0] last_line;
  int            n_vec  = 0;
  int            n_miss = 0;
  int            n_rd   = 0;
  int            n_wr   = 0;

  function automatic logic [BW-1:0] b64(input logic [3:0] n);
    return {16{n}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_busy(input bit is_write);
    check("read_o",    LW'(read_o),   LW'(!is_write));
    check("write_o",   LW'(write_o),  LW'(is_write));
    check("resp_busy", LW'(resp_o),   '0);
    check("addr_busy", LW'(address_o), LW'(cur_addr));
  endtask

  task automatic check_beat(input string name, input bit pop);
    if (exp_beats.size() == 0) begin
      check({name, "_underflow"}, LW'(burst_o), {LW{1'bx}});
    end else begin
      check(name, LW'(burst_o), LW'(exp_beats[0]));
      if (pop) void'(exp_beats.pop_front());
    end
  endtask

  // Entered #1 after the edge that starts the first burst cycle; returns
  // #1 after the edge that enters DONE.
  task automatic do_beats(input bit is_write, input logic [LW-1:0] data,
                          input int stall_beat, input int stall_n);
    for (int b = 0; b < NB; b++) begin
      for (int w = 0; w < ((b == stall_beat) ? stall_n : 0); w++) begin
        resp_i  = 1'b0;
        burst_i = '0;
        @(negedge clk);
        check_busy(is_write);
        if (is_write) check_beat("burst_stall", 1'b0);
        @(posedge clk); #1;
      end
      resp_i  = 1'b1;
      burst_i = data[b*BW +: BW];
      @(negedge clk);
      check_busy(is_write);
      if (is_write) check_beat("burst_ack", 1'b1);
      @(posedge clk); #1;
    end
    resp_i  = 1'b0;
    burst_i = '0;
  endtask

  // Checks the DONE cycle and the following IDLE cycle; returns at that negedge.
  task automatic do_done(input bit is_write, input logic [31:0] exp_addr);
    @(negedge clk);
    check("resp_done",  LW'(resp_o),  LW'(1));
    check("rd_in_done", LW'(read_o),  '0);
    check("wr_in_done", LW'(write_o), '0);
    check("addr_done",  LW'(address_o), LW'(exp_addr));
    if (is_write) begin
      n_wr++;
    end else begin
      n_rd++;
      if (exp_lines.size() == 0) check("line_underflow", line_o, {LW{1'bx}});
      else begin
        last_line = exp_lines.pop_front();
        check("line_done", line_o, last_line);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("resp_pulse", LW'(resp_o),  '0);
    check("rd_idle",    LW'(read_o),  '0);
    check("wr_idle",    LW'(write_o), '0);
    check("line_held",  line_o, last_line);
  endtask

  task automatic run_txn(input vec_t v);
    read_i    = !v.is_write;
    write_i   = v.is_write;
    address_i = v.addr;
    line_i    = v.is_write ? v.line : ~v.line;
    cur_addr  = v.addr & 32'hFFFF_FFE0;
    if (v.is_write) for (int b = 0; b < NB; b++) exp_beats.push_back(v.line[b*BW +: BW]);
    else            exp_lines.push_back(v.line);
    @(posedge clk); #1;
    read_i  = 1'b0;
    write_i = 1'b0;
    do_beats(v.is_write, v.line, v.stall_beat, v.stall_n);
    do_done(v.is_write, cur_addr);
  endtask

  initial begin
    logic [LW-1:0] l_r, l_w;

    vecs[0] = '{1'b0, 32'h0000_1234, {b64(4'h4), b64(4'h3), b64(4'h2), b64(4'h1)}, -1, 0};
    vecs[1] = '{1'b1, 32'h0000_8040, {b64(4'hD), b64(4'hC), b64(4'hB), b64(4'hA)},  1, 2};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                      64'hDEAD_BEEF_CAFE_F00D, 64'h0}, 3, 1};
    vecs[3] = '{1'b1, 32'h0000_003F, {64'h1, 64'h8000_0000_0000_0000,
                                      64'h5555_AAAA_5555_AAAA, 64'hFFFF_FFFF_FFFF_FFFF}, 0, 3};
    vecs[4] = '{1'b0, 32'h1357_9BDF, {64'hA5A5_0000_5A5A_FFFF, 64'h0F0F_F0F0_0F0F_F0F0,
                                      64'h7777_6666_5555_4444, 64'h3333_2222_1111_0000}, 2, 2};

    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    cur_addr = '0; last_line = '0;
    #2;
    check("rst_read_o",  LW'(read_o),   '0);
    check("rst_write_o", LW'(write_o),  '0);
    check("rst_resp_o",  LW'(resp_o),   '0);
    check("rst_addr_o",  LW'(address_o), '0);
    check("rst_line_o",  line_o,         '0);
    check("rst_burst_o", LW'(burst_o),  '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset two beats into a read: outputs drop at once, no completion.
    read_i = 1'b1; address_i = 32'h0000_5678;
    @(posedge clk); #1;
    read_i = 1'b0;
    resp_i = 1'b1;
    for (int b = 0; b < 2; b++) begin
      burst_i = b64(4'(b + 6));
      @(posedge clk); #1;
    end
    resp_i = 1'b0;
    @(negedge clk);
    check("mid_read_o", LW'(read_o), LW'(1));
    rst = 1'b0;
    #1;
    check("mrst_read_o", LW'(read_o), '0);
    check("mrst_resp_o", LW'(resp_o), '0);
    check("mrst_line_o", line_o, '0);
    check("mrst_addr_o", LW'(address_o), '0);
`ifdef CACHELINE_ADAPTER_PERF_EN
    check("mrst_rd_cnt", LW'(rd_count_o), '0);
    check("mrst_wr_cnt", LW'(wr_count_o), '0);
`endif
    n_rd = 0; n_wr = 0;
    repeat (2) @(negedge clk);
    check("mrst_no_resp", LW'(resp_o), '0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);
`ifdef CACHELINE_ADAPTER_PERF_EN
    check("perf_rd_cnt", LW'(rd_count_o), LW'(n_rd));
    check("perf_wr_cnt", LW'(wr_count_o), LW'(n_wr));
`endif

    // Stray acknowledges in IDLE must not start anything.
    resp_i = 1'b1; burst_i = b64(4'h9);
    repeat (3) begin
      @(negedge clk);
      check("stray_read_o",  LW'(read_o),  '0);
      check("stray_write_o", LW'(write_o), '0);
      check("stray_resp_o",  LW'(resp_o),  '0);
      check("stray_line_o",  line_o, last_line);
    end
    resp_i = 1'b0; burst_i = '0;

    // Read and write together: read first, then the still-held write.
    l_r = {b64(4'hE), b64(4'h0), b64(4'hF), b64(4'h8)};
    l_w = {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000};
    exp_lines.push_back(l_r);
    for (int b = 0; b < NB; b++) exp_beats.push_back(l_w[b*BW +: BW]);
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_2468; line_i = l_w;
    cur_addr = 32'h0000_2460;
    @(posedge clk); #1;
    do_beats(1'b0, l_r, -1, 0);
    read_i = 1'b0;
    address_i = 32'h0000_9999;
    do_done(1'b0, 32'h0000_2460);
    cur_addr = 32'h0000_9980;
    @(posedge clk); #1;
    write_i = 1'b0;
    do_beats(1'b1, l_w, 2, 1);
    do_done(1'b1, 32'h0000_9980);
    check("sb_beats_empty", LW'(exp_beats.size()), '0);
    check("sb_lines_empty", LW'(exp_lines.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Converts whole-cache-line transfers from the L2 cache into fixed-length bursts on the physical memory port, and collects returning bursts back into full lines. It sits directly downstream of the L1↔L2 line-wide bus adapter path: the L2 miss/writeback logic drives it with one line-wide request, and it performs one burst per request on the 64-bit memory bus.

## Interface
- `s_offset`, default 5: line offset bits. The line is 2**s_offset bytes, i.e. 256 bits.
- `beat_width`, default 64: memory data width per beat.
- Derived constant `num_beats` = (2**s_offset*8)/beat_width, default 4. It must be a power of two and ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `line_i`  in  2**s_offset*8  writeback line from L2.
- `line_o`  out  2**s_offset*8  assembled fill line to L2.
- `address_i`  in  32  line address from L2.
- `read_i`  in  1  line fill request.
- `write_i`  in  1  line writeback request.
- `resp_o`  out  1  one-cycle completion pulse to L2.
- `burst_i`  in  beat_width  read beat from memory.
- `burst_o`  out  beat_width  write beat to memory.
- `address_o`  out  32  burst address; the low s_offset bits are zero.
- `read_o`  out  1  memory burst read.
- `write_o`  out  1  memory burst write.
- `resp_i`  in  1  memory beat acknowledge, one per beat.

## Operation
- States:
  - IDLE.
  - READ: collecting beats.
  - WRITE: sending beats.
  - DONE: resp_o pulse.
- **IDLE:**
  - On `read_i`, latch `address_i` with the low s_offset bits cleared, clear the beat counter, and go to READ.
  - Else on `write_i`, latch the address and `line_i`, clear the beat counter, and go to WRITE.
  - If both are asserted, read wins; `write_i` is serviced after the read completes if it is still high.
- **READ:**
  - `read_o`=1 for the whole state.
  - Each cycle with `resp_i`=1, write `burst_i` into line buffer bits [beat_width*k +: beat_width], where k is the beat counter, then increment k.
  - On the beat where k=num_beats-1, go to DONE.
- **WRITE:**
  - `write_o`=1 for the whole state.
  - `burst_o` = latched line [beat_width*k +: beat_width], combinational on k.
  - On `resp_i`, increment k. After the last beat, go to DONE.
- **DONE:**
  - `resp_o`=1 for exactly one cycle, then go to IDLE.
  - `line_o` = line buffer. It is valid in DONE and held unchanged until the next READ beat overwrites it.
- `resp_i` outside READ/WRITE is ignored.
- `read_i`/`write_i` changes during READ, WRITE or DONE are ignored. The requester deasserts them in the DONE cycle.
- `address_o` holds the latched address from the state-entry cycle through DONE.

## Timing
- Reset values:
  - state=IDLE.
  - `read_o`=`write_o`=`resp_o`=0.
  - `address_o`=0, `line_o`=0, `burst_o`=0, beat counter=0.
- Request accepted in cycle t. `read_o`/`write_o` high from t+1.
- With `resp_i` high every cycle from t+1, `resp_o` is high in cycle t+num_beats+1. Minimum latency is 5 cycles at defaults.
- Memory wait states stall the counter; there is no timeout.
- Back-to-back: a new request can be accepted in the IDLE cycle after DONE. Minimum spacing is num_beats+2 cycles.
- Reset asserted mid-burst: immediately return to IDLE and drop `read_o`/`write_o`. The partial line is discarded and no `resp_o` is produced.
- Beat counter width is log2(num_beats). Wrap-around is never relied on, because the state changes on the last beat.

## Configuration
- `CACHELINE_ADAPTER_PERF_EN`: when defined, adds two outputs, `rd_count_o` and `wr_count_o`, each 32 bits.
  - Each increments in its DONE cycle, according to the transaction type.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `cache_types`:
  - state enum `cla_state_t` {IDLE, READ, WRITE, DONE}.
  - `num_beats` helper function.
  - Default line and beat width constants shared with the L2 and the bus adapter.
- Single module, no sub-module. The beat counter and line buffer are inline.

## Test plan
- **Read fill:** `read_i`=1, `address_i`=32'h0000_1234; memory returns beats 64'h1111…, 64'h2222…, 64'h3333…, 64'h4444… on consecutive cycles.
  - Expect `address_o`=32'h0000_1220.
  - Expect `line_o`={4444…,3333…,2222…,1111…}.
  - Expect `resp_o` exactly 1 cycle, 5 cycles after acceptance.
- **Writeback:** `write_i`=1, `line_i`={D,C,B,A}; memory inserts 2 wait cycles before beat 2.
  - Expect `burst_o` sequence A,B,B,B,C,D across the `resp_i` cycles.
  - Expect `write_o` continuously high; `resp_o` after the 4th ack.
- **Simultaneous requests:** `read_i`=`write_i`=1 in IDLE.
  - Expect the read burst first, then the write burst when `write_i` is still held.
- **Reset mid-read:** `rst` low after beat 2.
  - Expect `read_o`=0 and `resp_o`=0 immediately; after release, a new read completes correctly.
- **Stray acknowledge:** `resp_i` pulsed in IDLE.
  - Expect no state change and no `resp_o`.
- **With CACHELINE_ADAPTER_PERF_EN:** 3 reads and 2 writes.
  - Expect `rd_count_o`=3 and `wr_count_o`=2; both 0 after reset.
